apx_float_addsub: RTL and testbench

Parametrised approximate IEEE-754-style floating-point adder/subtractor with configurable exponent and mantissa widths and a configurable number of truncated (approximated) mantissa LSBs. Operands arrive on two stb/ack channels and the result leaves on a third. An `op` bit selects add or subtract. Compared with the single-precision adder, it adds:

- Width generalisation (half, single, or custom formats).
- Bounded alignment.
- Correct inf−inf → NaN handling.
- Forced zeroing of the truncated result bits.

It sits in the float_ops_apx library as a drop-in arithmetic unit for accuracy/energy sweeps.

---
 rtl/apx_float_addsub.sv | 243 ++++++++++++++++++++++++
 tb/tb_apx_float_addsub.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/apx_float_addsub.sv
// Approximate floating-point adder/subtractor with stb/ack operand and result channels.
// Define APX_FLOAT_BT_RND_EN to pre-round the truncated operand LSBs (adds the BT_RND state).
module apx_float_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int NAB_M = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     input_a,
    input  logic                     input_a_stb,
    output logic                     input_a_ack,
    input  logic [EXP_W+MAN_W:0]     input_b,
    input  logic                     input_b_stb,
    output logic                     input_b_ack,
    input  logic                     op,
    output logic [EXP_W+MAN_W:0]     output_z,
    output logic                     output_z_stb,
    input  logic                     output_z_ack
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int K    = MAN_W - NAB_M;
    localparam int KP1  = K + 1;
    localparam int MW   = K + 4;
    localparam int EW   = EXP_W + 2;
    localparam int EW1  = EW + 1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] E_BIAS    = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX     = EW'(BIAS + 1);
    localparam logic signed [EW-1:0] E_MIN     = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] E_ZERO    = EW'(-BIAS);
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic signed [EW:0]   ALIGN_MAX = EW1'(K + 3);
    localparam logic signed [EW:0]   ALIGN_MIN = EW1'(-(K + 3));
    localparam logic [K:0]           M_ONE     = KP1'(1);
    localparam logic [W-1:0]         NAN_Z     = W'({(EXP_W + 2){1'b1}}) << (MAN_W - 1);
`ifdef APX_FLOAT_BT_RND_EN
    localparam int                   RB        = (NAB_M > 0) ? NAB_M - 1 : 0;
    localparam logic [W-1:0]         RND_INC   = W'(1) << NAB_M;
`endif

    typedef enum logic [3:0] {
        GET_A, GET_B, BT_RND, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
        NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, next_state;

    logic [W-1:0]         a, b, z;
    logic                 op_r;
    logic [MW-1:0]        a_m, b_m;
    logic signed [EW-1:0] a_e, b_e, z_e;
    logic                 a_s, b_s, z_s;
    logic [MW:0]          sum;
    logic [K:0]           z_m;
    logic                 guard, rnd, sticky;

    logic signed [EW:0]   e_diff;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit;
    logic [EXP_W-1:0]     a_eb, b_eb, z_eb;
    logic [MAN_W-1:0]     a_frac, b_frac, z_frac;
    logic [W-1:0]         spec_z, pack_z;
    logic                 norm1_shift, norm2_shift;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        e_diff      = {a_e[EW-1], a_e} - {b_e[EW-1], b_e};
        a_nan       = (a_e == E_MAX) && (a_m != '0);
        b_nan       = (b_e == E_MAX) && (b_m != '0);
        a_inf       = (a_e == E_MAX) && (a_m == '0);
        b_inf       = (b_e == E_MAX) && (b_m == '0);
        a_zero      = (a_e == E_ZERO) && (a_m == '0);
        b_zero      = (b_e == E_ZERO) && (b_m == '0);
        a_eb        = EXP_W'(a_e + E_BIAS);
        b_eb        = EXP_W'(b_e + E_BIAS);
        a_frac      = MAN_W'(a_m[K+2:3]) << NAB_M;
        b_frac      = MAN_W'(b_m[K+2:3]) << NAB_M;
        special_hit = 1'b1;
        spec_z      = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) spec_z = NAN_Z;
        else if (a_inf)              spec_z = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (b_inf)              spec_z = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero && b_zero)   spec_z = {a_s & b_s, {(W - 1){1'b0}}};
        else if (a_zero)             spec_z = {b_s, b_eb, b_frac};
        else if (b_zero)             spec_z = {a_s, a_eb, a_frac};
        else                         special_hit = 1'b0;

        norm1_shift = !z_m[K] && (z_e > E_MIN);
        norm2_shift = z_e < E_MIN;

        z_eb   = EXP_W'(z_e + E_BIAS);
        z_frac = MAN_W'(z_m[K-1:0]) << NAB_M;
        pack_z = {z_s, z_eb, z_frac};
        if (z_e == E_MIN && !z_m[K]) pack_z[W-2:MAN_W] = '0;
        if (z_e > E_BIAS)            pack_z = {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= GET_A;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            GET_A:   if (input_a_ack && input_a_stb) next_state = GET_B;
`ifdef APX_FLOAT_BT_RND_EN
            GET_B:   if (input_b_ack && input_b_stb) next_state = BT_RND;
            BT_RND:  next_state = UNPACK;
`else
            GET_B:   if (input_b_ack && input_b_stb) next_state = UNPACK;
`endif
            UNPACK:  next_state = SPECIAL;
            SPECIAL: next_state = special_hit ? PUT_Z : ALIGN;
            ALIGN:   if (e_diff == '0) next_state = ADD_0;
            ADD_0:   next_state = ADD_1;
            ADD_1:   next_state = NORM_1;
            NORM_1:  if (!norm1_shift) next_state = NORM_2;
            NORM_2:  if (!norm2_shift) next_state = ROUND;
            ROUND:   next_state = PACK;
            PACK:    next_state = PUT_Z;
            PUT_Z:   if (output_z_stb && output_z_ack) next_state = GET_A;
            default: next_state = GET_A;
        endcase
    end

    // NOTE: only handshake/output registers are reset; datapath registers are always written before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
        end else begin
            case (state)
                GET_A: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                    end
                end
                GET_B: begin
                    input_b_ack <= 1'b1;
                    if (input_b_ack && input_b_stb) begin
                        b           <= input_b;
                        op_r        <= op;
                        input_b_ack <= 1'b0;
                    end
                end
`ifdef APX_FLOAT_BT_RND_EN
                BT_RND: begin
                    if (NAB_M > 0 && a[RB]) a <= a + RND_INC;
                    if (NAB_M > 0 && b[RB]) b <= b + RND_INC;
                end
`endif
                UNPACK: begin
                    a_m <= {1'b0, a[MAN_W-1:NAB_M], 3'b000};
                    b_m <= {1'b0, b[MAN_W-1:NAB_M], 3'b000};
                    a_e <= $signed({2'b00, a[W-2:MAN_W]}) - E_BIAS;
                    b_e <= $signed({2'b00, b[W-2:MAN_W]}) - E_BIAS;
                    a_s <= a[W-1];
                    b_s <= b[W-1] ^ op_r;
                end
                SPECIAL: begin
                    z <= spec_z;
                    if (a_e == E_ZERO) a_e <= E_MIN;
                    else               a_m[MW-1] <= 1'b1;
                    if (b_e == E_ZERO) b_e <= E_MIN;
                    else               b_m[MW-1] <= 1'b1;
                end
                ALIGN: begin
                    // Far-apart operands collapse to a lone sticky bit instead of shifting K+3+ times.
                    if (e_diff > ALIGN_MAX) begin
                        b_m <= MW'(|b_m);
                        b_e <= a_e;
                    end else if (e_diff < ALIGN_MIN) begin
                        a_m <= MW'(|a_m);
                        a_e <= b_e;
                    end else if (!e_diff[EW] && e_diff != '0) begin
                        b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
                        b_e <= b_e + E_ONE;
                    end else if (e_diff[EW]) begin
                        a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
                        a_e <= a_e + E_ONE;
                    end
                end
                ADD_0: begin
                    z_e <= a_e;
                    if (a_s == b_s) begin
                        sum <= {1'b0, a_m} + {1'b0, b_m};
                        z_s <= a_s;
                    end else if (a_m >= b_m) begin
                        sum <= {1'b0, a_m} - {1'b0, b_m};
                        z_s <= (a_m == b_m) ? 1'b0 : a_s;
                    end else begin
                        sum <= {1'b0, b_m} - {1'b0, a_m};
                        z_s <= b_s;
                    end
                end
                ADD_1: begin
                    if (sum[MW]) begin
                        z_m    <= sum[MW:4];
                        guard  <= sum[3];
                        rnd    <= sum[2];
                        sticky <= sum[1] | sum[0];
                        z_e    <= z_e + E_ONE;
                    end else begin
                        z_m    <= sum[MW-1:3];
                        guard  <= sum[2];
                        rnd    <= sum[1];
                        sticky <= sum[0];
                    end
                end
                NORM_1: if (norm1_shift) begin
                    z_e   <= z_e - E_ONE;
                    z_m   <= {z_m[K-1:0], guard};
                    guard <= rnd;
                    rnd   <= 1'b0;
                end
                NORM_2: if (norm2_shift) begin
                    z_e    <= z_e + E_ONE;
                    z_m    <= {1'b0, z_m[K:1]};
                    guard  <= z_m[0];
                    rnd    <= guard;
                    sticky <= sticky | rnd;
                end
                ROUND: if (guard && (rnd || sticky || z_m[0])) begin
                    z_m <= z_m + M_ONE;
                    if (&z_m) z_e <= z_e + E_ONE;
                end
                PACK: z <= pack_z;
                PUT_Z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= z;
                    if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apx_float_addsub.sv
// Directed bench for apx_float_addsub: single precision (NAB_M 0 and 8) and half precision instances.
module tb_apx_float_addsub;
    localparam int LIMIT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b;
    logic        op_i;
    logic [2:0]  a_stb, b_stb, z_ack;
    wire  [2:0]  a_ack, b_ack, z_stb;
    wire  [31:0] z0, z1;
    wire  [15:0] z2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] res;
    int          lat, lat_basic, lat_far, lat_col;

    always #5 clk = ~clk;

    apx_float_addsub u_sp (
        .clk(clk), .rst(rst),
        .input_a(in_a), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
        .input_b(in_b), .input_b_stb(b_stb[0]), .input_b_ack(b_ack[0]),
        .op(op_i),
        .output_z(z0), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0])
    );

    apx_float_addsub #(.NAB_M(8)) u_tr (
        .clk(clk), .rst(rst),
        .input_a(in_a), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
        .input_b(in_b), .input_b_stb(b_stb[1]), .input_b_ack(b_ack[1]),
        .op(op_i),
        .output_z(z1), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1])
    );

    apx_float_addsub #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst(rst),
        .input_a(in_a[15:0]), .input_a_stb(a_stb[2]), .input_a_ack(a_ack[2]),
        .input_b(in_b[15:0]), .input_b_stb(b_stb[2]), .input_b_ack(b_ack[2]),
        .op(op_i),
        .output_z(z2), .output_z_stb(z_stb[2]), .output_z_ack(z_ack[2])
    );

    function automatic logic [31:0] get_z(input int idx);
        case (idx)
            0:       return z0;
            1:       return z1;
            default: return {16'h0000, z2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on DUT idx; cycles counts negedges from the B-capture edge until output stb.
    task automatic run(input int idx, input logic [31:0] a, input logic [31:0] b, input logic o,
                       input int hold, input int abort, output logic [31:0] z, output int cycles);
        int   n;
        logic late;
        logic stable;
        late   = 1'b0;
        stable = 1'b1;
        z      = '0;
        cycles = 0;
        in_a = a;
        in_b = b;
        op_i = o;
        a_stb[idx] = 1'b1;
        n = 0;
        while (a_ack[idx] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        late = late | (n >= LIMIT);
        @(negedge clk);
        a_stb[idx] = 1'b0;
        b_stb[idx] = 1'b1;
        n = 0;
        while (b_ack[idx] !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
        late = late | (n >= LIMIT);
        @(negedge clk);
        b_stb[idx] = 1'b0;
        if (abort > 0) begin
            repeat (abort) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("abort_no_timeout", 32'(late), 32'd0);
            return;
        end
        while (z_stb[idx] !== 1'b1 && cycles < LIMIT) begin @(negedge clk); cycles++; end
        late = late | (cycles >= LIMIT);
        check("no_timeout", 32'(late), 32'd0);
        z = get_z(idx);
        repeat (hold) begin
            @(negedge clk);
            if (get_z(idx) !== z || z_stb[idx] !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 32'(stable), 32'd1);
        z_ack[idx] = 1'b1;
        @(negedge clk);
        z_ack[idx] = 1'b0;
        check("stb_drop", 32'(z_stb[idx]), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        in_a  = '0;
        in_b  = '0;
        op_i  = 1'b0;
        a_stb = '0;
        b_stb = '0;
        z_ack = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({a_ack, b_ack, z_stb}), 32'd0);
        check("reset_z", z0 | z1 | {16'h0000, z2}, 32'd0);
        rst = 1'b0;

        run(0, 32'h3F800000, 32'h40000000, 1'b0, 0, 0, res, lat_basic);
        check("add_1_2", res, 32'h40400000);

        run(0, 32'h3F800000, 32'h3F800000, 1'b1, 0, 0, res, lat);
        check("sub_to_zero", res, 32'h00000000);

        run(0, 32'h3F800000, 32'h40000000, 1'b1, 0, 0, res, lat);
        check("sub_neg", res, 32'hBF800000);

        run(0, 32'h7F800000, 32'hFF800000, 1'b0, 0, 0, res, lat);
        check("inf_minus_inf", res, 32'hFFC00000);

        run(0, 32'h7F800000, 32'h3F800000, 1'b0, 0, 0, res, lat);
        check("inf_plus_one", res, 32'h7F800000);

        run(0, 32'h7FC00000, 32'h3F800000, 1'b0, 0, 0, res, lat);
        check("nan_in", res, 32'hFFC00000);

        run(0, 32'h3F800001, 32'h33800000, 1'b0, 0, 0, res, lat);
        check("round_tie_up", res, 32'h3F800002);

        run(0, 32'h00000001, 32'h00000001, 1'b0, 0, 0, res, lat);
        check("denormal_add", res, 32'h00000002);

        run(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 0, res, lat);
        check("overflow_inf", res, 32'h7F800000);

        run(0, 32'h4B800000, 32'h3F800000, 1'b0, 0, 0, res, lat_far);
        check("align_tie_even", res, 32'h4B800000);
        check("align_24_shifts", 32'(lat_far - lat_basic), 32'd23);

        run(0, 32'h4F800000, 32'h3F800000, 1'b0, 0, 0, res, lat_col);
        check("align_collapse_b", res, 32'h4F800000);
        check("collapse_latency", 32'(lat_col), 32'(lat_basic));

        run(0, 32'h3F800000, 32'h4F800000, 1'b0, 0, 0, res, lat);
        check("align_collapse_a", res, 32'h4F800000);

        run(1, 32'h3F8000FF, 32'h00000000, 1'b0, 0, 0, res, lat);
`ifdef APX_FLOAT_BT_RND_EN
        check("trunc_prerounded", res, 32'h3F800100);
`else
        check("trunc_plain", res, 32'h3F800000);
`endif
        check("trunc_low_zero", 32'(res[7:0]), 32'd0);

        run(2, 32'h00003C00, 32'h00003C00, 1'b0, 0, 0, res, lat);
        check("half_add", res, 32'h00004000);

        run(2, 32'h00004000, 32'h00003C00, 1'b1, 0, 0, res, lat);
        check("half_sub", res, 32'h00003C00);

        run(0, 32'h40400000, 32'h3F800000, 1'b0, 20, 0, res, lat);
        check("hold_result", res, 32'h40800000);

        run(0, 32'h4B800000, 32'h3F800000, 1'b0, 0, 4, res, lat);
        check("abort_ctrl", 32'({a_ack[0], b_ack[0], z_stb[0]}), 32'd0);
        check("abort_z", z0, 32'd0);

        run(0, 32'h3F800000, 32'h40000000, 1'b0, 0, 0, res, lat);
        check("after_abort", res, 32'h40400000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
